// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_wr_if : requester, fill-control and framebuffer write bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fb_wr_if #(
  parameter int ADDR_W = 19
);
  logic              clear_start;
  logic              clear_value;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_data;
  logic              b_ready;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_data;
  logic              clear_busy;
  logic              clear_done;
  logic              oor_drop;

  modport master (
    output clear_start, clear_value,
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  fb_we, fb_addr, fb_data, clear_busy, clear_done, oor_drop
  );

  modport slave (
    input  clear_start, clear_value,
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output fb_we, fb_addr, fb_data, clear_busy, clear_done, oor_drop
  );
endinterface
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_write_arbiter : round-robin A/B framebuffer writer with full fill |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fb_write_arbiter #(
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int ADDR_W = 19
) (
  input  logic   clk,
  input  logic   rst,
  fb_wr_if.slave bus
);
  localparam logic [0:0]        c_ARB   = 1'b0;
  localparam logic [0:0]        c_CLEAR = 1'b1;
  localparam logic [ADDR_W:0]   c_NPIX  = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(FB_W * FB_H - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_clr_val;
  logic              r_last_b;
  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic              r_fb_data;
  logic              r_busy;
  logic              r_done;
  logic              r_oor;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_a_xfer;
  logic              w_b_xfer;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_req_data;
  logic              w_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ARB;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ARB:   if (bus.clear_start) w_next_state = c_CLEAR;
      c_CLEAR: if (r_cnt == c_LAST) w_next_state = c_ARB;
      default: w_next_state = c_ARB;
    endcase
  end

  // Grant on a tie goes to whichever requester was not served last.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (r_state == c_ARB && !bus.clear_start) begin
      if (bus.a_valid && (!bus.b_valid || r_last_b)) w_a_ready = 1'b1;
      else if (bus.b_valid)                          w_b_ready = 1'b1;
    end
  end

  assign w_a_xfer   = bus.a_valid && w_a_ready;
  assign w_b_xfer   = bus.b_valid && w_b_ready;
  assign w_req_addr = w_a_xfer ? bus.a_addr : bus.b_addr;
  assign w_req_data = w_a_xfer ? bus.a_data : bus.b_data;
  assign w_in_range = {1'b0, w_req_addr} < c_NPIX;
  assign w_cnt_nxt  = r_cnt + 1'b1;

  // Fill writes are presented while in CLEAR, so fb_addr tracks r_cnt there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clr_val <= 1'b0;
      r_last_b  <= 1'b1;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_fb_we <= 1'b0;
      r_done  <= 1'b0;
      r_oor   <= 1'b0;
      if (r_state == c_ARB) begin
        if (bus.clear_start) begin
          r_cnt     <= '0;
          r_clr_val <= bus.clear_value;
          r_fb_we   <= 1'b1;
          r_fb_addr <= '0;
          r_fb_data <= bus.clear_value;
          r_busy    <= 1'b1;
          r_done    <= (c_LAST == '0);
        end else if (w_a_xfer || w_b_xfer) begin
          r_last_b <= w_b_xfer;
          if (w_in_range) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_req_addr;
            r_fb_data <= w_req_data;
          end else begin
            r_oor <= 1'b1;
          end
        end
      end else if (r_cnt == c_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_cnt_nxt;
        r_fb_data <= r_clr_val;
        r_done    <= (w_cnt_nxt == c_LAST);
      end
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.b_ready    = w_b_ready;
  assign bus.fb_we      = r_fb_we;
  assign bus.fb_addr    = r_fb_addr;
  assign bus.fb_data    = r_fb_data;
  assign bus.clear_busy = r_busy;
  assign bus.clear_done = r_done;
  assign bus.oor_drop   = r_oor;
endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// Scoreboard bench for fb_write_arbiter on a reduced 16x8 framebuffer.
module tb_fb_write_arbiter;
  localparam int W = 16, H = 8, AW = 8, NPIX = W * H;

  typedef struct {
    int          tag;
    bit          we;
    logic [AW-1:0] addr;
    bit          data;
    bit          oor;
    bit          busy;
    bit          done;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  rec_t sb[$];
  rec_t mr;
  logic [AW-1:0] h_addr = '0;
  bit   h_data = 1'b0;
  bit   m_last_b = 1'b1;
  int   m_clear_end = -1;

  fb_wr_if #(.ADDR_W(AW)) bus();

  fb_write_arbiter #(.FB_W(W), .FB_H(H), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compares each cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      h_addr = '0;
      h_data = 1'b0;
    end else begin
      while (sb.size() > 0 && sb[0].tag < cyc) begin
        chk("missed_write_cycle", sb[0].tag, cyc);
        void'(sb.pop_front());
      end
      mr = '{tag: cyc, we: 1'b0, addr: h_addr, data: h_data, oor: 1'b0, busy: 1'b0, done: 1'b0};
      if (sb.size() > 0 && sb[0].tag == cyc) mr = sb.pop_front();
      chk("fb_we", int'(bus.fb_we), int'(mr.we));
      chk("oor_drop", int'(bus.oor_drop), int'(mr.oor));
      chk("clear_busy", int'(bus.clear_busy), int'(mr.busy));
      chk("clear_done", int'(bus.clear_done), int'(mr.done));
      if (mr.we) begin
        h_addr = mr.addr;
        h_data = mr.data;
      end
      chk("fb_addr", int'(bus.fb_addr), int'(h_addr));
      chk("fb_data", int'(bus.fb_data), int'(h_data));
    end
  end

  // Apply one cycle of stimulus (called at posedge+1) and predict its effect.
  task automatic cycle(bit cs, bit cv, bit av, logic [AW-1:0] aa, bit ad,
                       bit bv, logic [AW-1:0] ba, bit bd);
    bit ea, eb, in_clear;
    rec_t r;
    bus.clear_start = cs; bus.clear_value = cv;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    #1;
    in_clear = (cyc <= m_clear_end);
    ea = 1'b0;
    eb = 1'b0;
    if (!in_clear && !cs) begin
      if (av && bv) begin
        ea = m_last_b;
        eb = !m_last_b;
      end else begin
        ea = av;
        eb = bv;
      end
    end
    chk("a_ready", int'(bus.a_ready), int'(ea));
    chk("b_ready", int'(bus.b_ready), int'(eb));
    chk("one_grant", int'(bus.a_ready && bus.b_ready), 0);
    if (!in_clear) begin
      if (cs) begin
        for (int i = 0; i < NPIX; i++) begin
          r = '{tag: cyc + 1 + i, we: 1'b1, addr: AW'(i), data: cv, oor: 1'b0,
                busy: 1'b1, done: (i == NPIX - 1)};
          sb.push_back(r);
        end
        m_clear_end = cyc + NPIX;
      end else if (ea || eb) begin
        m_last_b = eb;
        r.tag  = cyc + 1;
        r.addr = ea ? aa : ba;
        r.data = ea ? ad : bd;
        r.we   = (int'(r.addr) < NPIX);
        r.oor  = !r.we;
        r.busy = 1'b0;
        r.done = 1'b0;
        sb.push_back(r);
      end
    end
  endtask

  task automatic step(bit cs, bit cv, bit av, logic [AW-1:0] aa, bit ad,
                      bit bv, logic [AW-1:0] ba, bit bd);
    @(posedge clk);
    #1;
    cycle(cs, cv, av, aa, ad, bv, ba, bd);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic drain_clear();
    int guard;
    guard = 0;
    while (cyc <= m_clear_end + 1 && guard < 4 * NPIX) begin
      idle();
      guard++;
    end
  endtask

  initial begin
    bus.clear_start = 0; bus.clear_value = 0;
    bus.a_valid = 0; bus.a_addr = '0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = '0; bus.b_data = 0;
    #2;
    chk("rst_fb_we", int'(bus.fb_we), 0);
    chk("rst_fb_addr", int'(bus.fb_addr), 0);
    chk("rst_fb_data", int'(bus.fb_data), 0);
    chk("rst_busy", int'(bus.clear_busy), 0);
    chk("rst_done", int'(bus.clear_done), 0);
    chk("rst_oor", int'(bus.oor_drop), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cycle(0, 0, 1, 8'd100, 1, 0, '0, 0);
    idle();

    repeat (4) step(0, 0, 1, 8'd20, 1, 1, 8'd30, 0);
    idle();

    step(1, 0, 1, 8'd5, 1, 0, '0, 0);
    for (int i = 1; i <= NPIX; i++)
      step(i == 10, 1, 1, 8'd5, 1, 0, '0, 0);
    step(0, 0, 1, 8'd7, 1, 0, '0, 0);
    idle();

    step(0, 0, 0, '0, 0, 1, 8'(NPIX), 1);
    step(0, 0, 0, '0, 0, 1, 8'd200, 1);
    step(0, 0, 0, '0, 0, 1, 8'(NPIX - 1), 1);
    idle();

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 159)), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 159)), 1'($urandom));
    drain_clear();
    idle();

    step(1, 1, 0, '0, 0, 0, '0, 0);
    repeat (40) idle();
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("abort_busy", int'(bus.clear_busy), 0);
    chk("abort_we", int'(bus.fb_we), 0);
    chk("abort_done", int'(bus.clear_done), 0);
    sb.delete();
    m_last_b = 1'b1;
    m_clear_end = -1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cycle(0, 0, 1, 8'd77, 1, 1, 8'd88, 0);
    step(0, 0, 1, 8'd66, 0, 1, 8'd55, 1);
    repeat (NPIX + 5) idle();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_W, default 640, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 480, framebuffer height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 19, framebuffer address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clear_start  input  1  one-cycle request to fill the whole framebuffer.
REQ-007 clear_value  input  1  fill pixel value, sampled when clear_start is accepted.
REQ-008 a_valid / a_addr / a_data  input  1 / ADDR_W / 1  requester A (mouse drawing) write request.
REQ-009 a_ready  output  1  requester A grant; transfer when a_valid && a_ready.
REQ-010 b_valid / b_addr / b_data  input  1 / ADDR_W / 1  requester B (text/overlay) write request.
REQ-011 b_ready  output  1  requester B grant; transfer when b_valid && b_ready.
REQ-012 fb_we / fb_addr / fb_data  output  1 / ADDR_W / 1  registered framebuffer write port.
REQ-013 clear_busy  output  1  high while the fill is in progress.
REQ-014 clear_done  output  1  one-cycle pulse on the last fill write.
REQ-015 oor_drop  output  1  one-cycle pulse when an accepted request address is out of range.

Function
REQ-016 SHALL implement two states: ARB (serve requesters) and CLEAR (fill).
REQ-017 In ARB with clear_start=1: no grant that cycle; latch clear_value; counter <= 0; next state CLEAR.
REQ-018 In CLEAR: clear_start ignored; a_ready=b_ready=0; one fill write per cycle, fb_addr = counter, fb_data = latched value, fb_we = 1.
REQ-019 Counter SHALL step 0 to FB_W*FB_H-1 (307199 default), giving exactly FB_W*FB_H writes; clear_done SHALL be high with the write at the last address; next state ARB.
REQ-020 clear_busy SHALL be high in every CLEAR cycle and low in ARB.
REQ-021 In ARB without clear_start: only one requester valid -> it is granted; both valid -> round-robin; the one not granted last wins.
REQ-022 last_grant register SHALL update only on a completed transfer.
REQ-023 Ready SHALL depend combinationally on state, clear_start, a_valid, b_valid and last_grant only; never on addresses or data.
REQ-024 Accepted in-range transfer (addr < FB_W*FB_H) SHALL appear on fb_we/fb_addr/fb_data exactly 1 cycle later.
REQ-025 Accepted out-of-range transfer SHALL complete the handshake, keep fb_we=0 and pulse oor_drop 1 cycle later.
REQ-026 fb_we SHALL be 0 in any ARB-driven cycle following a cycle with no transfer; fb_addr/fb_data hold last value.
REQ-027 At most one write per cycle; A and B SHALL never both be ready in the same cycle.

Reset
REQ-028 rst SHALL asynchronously force: state ARB, counter 0, last_grant = B (A wins first tie), fb_we=0, fb_addr=0, fb_data=0, clear_busy=0, clear_done=0, oor_drop=0.
REQ-029 rst asserted mid-CLEAR SHALL abort the fill with no clear_done; no resumption after release.
REQ-030 First cycle after rst release SHALL serve requests normally.

Verification
REQ-031 Reset, then a_valid=1, a_addr=1000, a_data=1 for one cycle -> a_ready=1 that cycle; next cycle fb_we=1, fb_addr=1000, fb_data=1.
REQ-032 a_valid and b_valid both held high for 4 cycles after reset -> grants A,B,A,B; fb_addr alternates a_addr, b_addr.
REQ-033 clear_start=1, clear_value=0 with a_valid=1 same cycle -> a_ready=0; then 307200 consecutive fb_we=1 cycles, fb_addr 0..307199, clear_done with addr 307199; a granted the cycle after CLEAR ends.
REQ-034 b_valid=1, b_addr=307200 -> b_ready=1; next cycle fb_we=0, oor_drop=1.
REQ-035 rst pulsed when fb_addr=5000 during CLEAR -> clear_busy=0 and fb_we=0 immediately, no clear_done ever; post-release a_valid served with 1-cycle latency.
REQ-036 clear_start pulsed again at counter=100 during CLEAR -> ignored; fill still ends at 307199 with a single clear_done.
